// File: rtl/adder_rr_scheduler_pkg.sv
// Shared types, constants and carry-lookahead helper for the round-robin adder scheduler.
package adder_sched_pkg;

  localparam int W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic sign;
    logic zero;
    logic parity;
    logic carry;
    logic overflow;
  } flags_t;

  // Carries c[0..4] of one 4-bit lookahead slice from generate/propagate and carry-in.
  function automatic logic [4:0] cla4_carries(input logic [3:0] g, input logic [3:0] p,
                                              input logic c0);
    logic [4:0] c;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | ((&p) & c0);
    return c;
  endfunction

endpackage

// File: rtl/adder_rr_scheduler_if.sv
// Request/response bundle between the client engines and the shared adder scheduler.
interface adder_rr_scheduler_if #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
);
  import adder_sched_pkg::*;

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_sub;
  logic [NREQ-1:0]   req_acc;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_sum;
  logic              rsp_sign;
  logic              rsp_zero;
  logic              rsp_parity;
  logic              rsp_carry;
  logic              rsp_overflow;

  modport master (
    output req_valid, req_a, req_b, req_sub, req_acc, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_sign, rsp_zero, rsp_parity,
           rsp_carry, rsp_overflow
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sub, req_acc, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_sign, rsp_zero, rsp_parity,
           rsp_carry, rsp_overflow
  );

endinterface

// File: rtl/adder_rr_scheduler_flags.sv
// Combinational 16-bit adder with carry-in and sign/zero/parity/carry/overflow flags,
// built from 4-bit carry-lookahead slices rippled slice to slice.
module adder_flags16
  import adder_sched_pkg::*;
(
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output flags_t       flags
);

  localparam int NSL = W / 4;

  logic [NSL:0] cs;
  logic         ovf;

  assign cs[0] = cin;

  for (genvar s = 0; s < NSL; s++) begin : g_slice
    logic [3:0] gen;
    logic [3:0] prop;
    logic [4:0] c;
    assign gen  = a[4*s +: 4] & b[4*s +: 4];
    assign prop = a[4*s +: 4] ^ b[4*s +: 4];
    assign c    = cla4_carries(gen, prop, cs[s]);
    assign sum[4*s +: 4] = prop ^ c[3:0];
    assign cs[s+1] = c[4];
  end

  // b is already the effective operand, so this covers subtract as well
  assign ovf   = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
  assign flags = {sum[W-1], ~|sum, ~^sum, cs[NSL], ovf};

endmodule

// File: rtl/adder_rr_scheduler.sv
// Round-robin scheduler sharing one adder/flag datapath among NREQ requesters.
// Optional ADDER_SCHED_ACCUM_EN adds a per-requester accumulator selectable as operand A.
module adder_rr_scheduler
  import adder_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  adder_rr_scheduler_if.slave   bus,
  output logic                  busy
);

  // state | meaning
  // IDLE  | no operation in flight; grant is combinational from req_valid and rr pointer
  // EXEC  | operands captured; shared adder evaluates, result and flags registered
  // RESP  | result presented on rsp_*; held until rsp_ready

  localparam int IW1 = IDW + 1;

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] gnt_idx;
  logic           gnt_found;
  logic [IW1-1:0] cand;
  logic           accept;
  logic           rsp_hs;

  logic [W-1:0]   a_cap;
  logic [W-1:0]   a_q, b_q, b_eff;
  logic           sub_q;
  logic [IDW-1:0] id_q;
  logic [W-1:0]   sum_c, sum_q;
  flags_t         flags_c, flags_q;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr} + IW1'(i);
      if (cand >= IW1'(NREQ)) cand = cand - IW1'(NREQ);
      if (!gnt_found && bus.req_valid[cand[IDW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[IDW-1:0];
      end
    end
  end

  assign accept = (state == IDLE) && gnt_found;
  assign rsp_hs = (state == RESP) && bus.rsp_ready;

  // Gated by rst_n so ready is low while reset is asserted even with valids pending
  assign bus.req_ready = (accept && rst_n) ? (NREQ'(1) << gnt_idx) : '0;

`ifdef ADDER_SCHED_ACCUM_EN
  logic [W-1:0] acc [NREQ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) acc[i] <= '0;
    end else if (rsp_hs) begin
      acc[id_q] <= sum_q;
    end
  end

  assign a_cap = bus.req_acc[gnt_idx] ? acc[gnt_idx] : bus.req_a[gnt_idx*W +: W];
`else
  logic unused_req_acc;
  assign unused_req_acc = ^bus.req_acc;
  assign a_cap = bus.req_a[gnt_idx*W +: W];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      id_q    <= '0;
      sum_q   <= '0;
      flags_q <= '0;
    end else begin
      if (accept) begin
        a_q   <= a_cap;
        b_q   <= bus.req_b[gnt_idx*W +: W];
        sub_q <= bus.req_sub[gnt_idx];
        id_q  <= gnt_idx;
        ptr   <= (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
      end
      if (state == EXEC) begin
        sum_q   <= sum_c;
        flags_q <= flags_c;
      end
    end
  end

  assign b_eff = sub_q ? ~b_q : b_q;

  adder_flags16 u_adder (
    .a     (a_q),
    .b     (b_eff),
    .cin   (sub_q),
    .sum   (sum_c),
    .flags (flags_c)
  );

  assign bus.rsp_valid    = (state == RESP);
  assign bus.rsp_id       = id_q;
  assign bus.rsp_sum      = sum_q;
  assign bus.rsp_sign     = flags_q.sign;
  assign bus.rsp_zero     = flags_q.zero;
  assign bus.rsp_parity   = flags_q.parity;
  assign bus.rsp_carry    = flags_q.carry;
  assign bus.rsp_overflow = flags_q.overflow;
  assign busy             = (state != IDLE);

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Scoreboard bench for adder_rr_scheduler: arithmetic reference model plus round-robin
// grant/latency model; ADDER_SCHED_ACCUM_EN also enables the accumulator model.
module tb_adder_rr_scheduler;
  import adder_sched_pkg::*;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
`ifdef ADDER_SCHED_ACCUM_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  always #5 clk = ~clk;

  adder_rr_scheduler_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  adder_rr_scheduler #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  typedef struct {
    int id;
    int sum;
    int sign;
    int zero;
    int parity;
    int carry;
    int ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   m_phase;      // 0 idle, 1 executing, 2 responding
  int   m_ptr;
  int   m_acc[NREQ];
  int   m_cur_id;
  int   m_cur_sum;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic done on plain integers: unsigned for sum/carry, signed range for overflow
  function automatic exp_t ref_op(int id, int a, int b, bit sub);
    exp_t e;
    int   full, sa, sb, sr;
    full     = sub ? (a + (b ^ 'hFFFF) + 1) : (a + b);
    e.id     = id;
    e.sum    = full & 'hFFFF;
    e.carry  = (full >> 16) & 1;
    sa       = (a >= 'h8000) ? a - 'h10000 : a;
    sb       = (b >= 'h8000) ? b - 'h10000 : b;
    sr       = sub ? sa - sb : sa + sb;
    e.ovf    = (sr > 32767 || sr < -32768) ? 1 : 0;
    e.sign   = (e.sum >> 15) & 1;
    e.zero   = (e.sum == 0) ? 1 : 0;
    e.parity = ($countones(e.sum) % 2 == 0) ? 1 : 0;
    return e;
  endfunction

  function automatic int pick(logic [NREQ-1:0] v, int p);
    for (int i = 0; i < NREQ; i++) begin
      if (v[(p + i) % NREQ]) return (p + i) % NREQ;
    end
    return -1;
  endfunction

  function automatic int rnd_val();
    case ($urandom_range(0, 5))
      0:       return 0;
      1:       return 'hFFFF;
      2:       return 'h8000;
      3:       return 'h7FFF;
      4:       return 1;
      default: return $urandom & 'hFFFF;
    endcase
  endfunction

  // Reference model: grant, two-cycle latency, response hold, accumulators
  initial begin
    int   g, a;
    exp_t e;
    m_phase = 0;
    m_ptr   = 0;
    for (int i = 0; i < NREQ; i++) m_acc[i] = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_phase = 0;
        m_ptr   = 0;
        exp_q.delete();
        for (int i = 0; i < NREQ; i++) m_acc[i] = 0;
      end else begin
        case (m_phase)
          0: begin
            g = pick(bus.req_valid, m_ptr);
            if (g >= 0) begin
              a = int'(bus.req_a[g*16 +: 16]);
              if (ACC_EN && bus.req_acc[g]) a = m_acc[g];
              e = ref_op(g, a, int'(bus.req_b[g*16 +: 16]), bus.req_sub[g]);
              exp_q.push_back(e);
              m_cur_id  = g;
              m_cur_sum = e.sum;
              m_ptr     = (g + 1) % NREQ;
              m_phase   = 1;
            end
          end
          1: m_phase = 2;
          default: begin
            if (bus.rsp_ready) begin
              if (ACC_EN) m_acc[m_cur_id] = m_cur_sum;
              m_phase = 0;
            end
          end
        endcase
      end
    end
  end

  // Monitor: checks grant/busy/valid every cycle and the presented response against the queue head
  initial begin
    int   g;
    int   exp_rdy;
    exp_t e;
    forever begin
      @(negedge clk);
      g = pick(bus.req_valid, m_ptr);
      exp_rdy = (g >= 0 && m_phase == 0 && rst_n) ? (1 << g) : 0;
      chk("req_ready", 32'(bus.req_ready), exp_rdy);
      chk("busy", 32'(busy), 32'(m_phase != 0));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_phase == 2));
      if (bus.rsp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rsp_unexpected: got rsp_valid=1 with id %0d, required no response at %0t",
                   bus.rsp_id, $time);
        end else begin
          e = exp_q[0];
          chk("rsp_id", 32'(bus.rsp_id), e.id);
          chk("rsp_sum", 32'(bus.rsp_sum), e.sum);
          chk("rsp_sign", 32'(bus.rsp_sign), e.sign);
          chk("rsp_zero", 32'(bus.rsp_zero), e.zero);
          chk("rsp_parity", 32'(bus.rsp_parity), e.parity);
          chk("rsp_carry", 32'(bus.rsp_carry), e.carry);
          chk("rsp_overflow", 32'(bus.rsp_overflow), e.ovf);
          if (bus.rsp_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic drive(int i, int a, int b, bit sub, bit acc);
    bus.req_a[i*16 +: 16] = 16'(a);
    bus.req_b[i*16 +: 16] = 16'(b);
    bus.req_sub[i]        = sub;
    bus.req_acc[i]        = acc;
    bus.req_valid[i]      = 1'b1;
  endtask

  // Holds requester i valid until its grant edge, then drops it
  task automatic wait_grant(int i);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (bus.req_ready[i] !== 1'b1 && t < 200);
    if (bus.req_ready[i] !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL grant_timeout: requester %0d got no ready, required one within 200 cycles", i);
    end
    @(posedge clk);
    #1;
    bus.req_valid[i] = 1'b0;
  endtask

  task automatic issue(int i, int a, int b, bit sub, bit acc);
    drive(i, a, b, sub, acc);
    wait_grant(i);
  endtask

  task automatic wait_quiet();
    int t = 0;
    while ((m_phase != 0 || exp_q.size() != 0) && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    if (m_phase != 0 || exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_sub   = '0;
    bus.req_acc   = '0;
    bus.rsp_ready = 1'b1;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rsp_sum", 32'(bus.rsp_sum), 0);
    chk("reset_rsp_id", 32'(bus.rsp_id), 0);
    chk("reset_rsp_carry", 32'(bus.rsp_carry), 0);
    chk("reset_busy", 32'(busy), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue(0, 'h1234, 'h0001, 1'b0, 1'b0);
    wait_quiet();
    issue(0, 'h8000, 'h0001, 1'b1, 1'b0);
    wait_quiet();
    issue(2, 'hFFFF, 'h0001, 1'b0, 1'b0);
    wait_quiet();

    // Back-pressure: response held, requester 1 waits behind it
    bus.rsp_ready = 1'b0;
    issue(3, 'h7FFF, 'h7FFF, 1'b0, 1'b0);
    drive(1, 'h0005, 'h0009, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    wait_grant(1);
    wait_quiet();

    // All requesters continuously valid
    for (int i = 0; i < NREQ; i++) drive(i, rnd_val(), rnd_val(), 1'($urandom_range(0, 1)), 1'b0);
    repeat (24) @(posedge clk);
    #1;
    bus.req_valid = '0;
    wait_quiet();

    // Reset while requester 1's operation is in EXEC; pointer would otherwise sit at 2
    issue(1, 'h0102, 'h0304, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_req_ready", 32'(bus.req_ready), 0);
    chk("rst_mid_rsp_sum", 32'(bus.rsp_sum), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(2, 'h0010, 'h0020, 1'b0, 1'b0);
    issue(0, 'h0030, 'h0040, 1'b0, 1'b0);
    wait_grant(2);
    wait_quiet();

    // Accumulator sequence on requester 1; requester 0 then reads its own accumulator
    issue(1, 'h1111, 5, 1'b0, 1'b1);
    wait_quiet();
    issue(1, 'h2222, 7, 1'b0, 1'b1);
    wait_quiet();
    issue(0, 'h0000, 0, 1'b0, 1'b1);
    wait_quiet();

    repeat (1500) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_valid[i] && $urandom_range(0, 7) == 0)
          bus.req_valid[i] = 1'b0;
        else if (!bus.req_valid[i] && $urandom_range(0, 2) == 0)
          drive(i, rnd_val(), rnd_val(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      bus.rsp_ready = ($urandom_range(0, 9) < 7);
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    wait_quiet();
    chk("queue_drained", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
